// File: rtl/seq_det_event_window.sv
// Windowed event counter for a serial "101" detector pulse stream.
// Counts rising edges of det_in over windows of WINDOW_CYCLES RUN cycles,
// then spends one REPORT cycle publishing count, overflow and minimum spacing.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   enable    in   level; high runs windows back-to-back, low aborts a window
//   clear     in   synchronous abort; returns to IDLE with report outputs reset
//   det_in    in   detector pulse (q_out of the upstream detector)
//   busy      out  high while in RUN or REPORT
//   win_valid out  one-cycle pulse while the report outputs are fresh
//   win_count out  events in the completed window, saturating
//   win_ovf   out  an event arrived while the count was saturated
//   min_gap   out  minimum cycles between consecutive events (all-ones if < 2)
module seq_det_event_window #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned GAP_W         = 8,
  parameter int unsigned WIN_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             det_in,
  output logic             busy,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_count,
  output logic             win_ovf,
  output logic [GAP_W-1:0] min_gap
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [GAP_W-1:0] GAP_MAX    = '1;
  localparam logic [WIN_W-1:0] TIMER_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_det_d;
  logic [WIN_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [GAP_W-1:0]   r_gap;
  logic               r_have_prev;
  logic [GAP_W-1:0]   r_mgap;
  logic               r_busy;
  logic               r_win_valid;
  logic [CNT_W-1:0]   r_win_count;
  logic               r_win_ovf;
  logic [GAP_W-1:0]   r_min_gap;

  logic               w_rise;
  logic [GAP_W-1:0]   w_gap_inc;
  logic [CNT_W-1:0]   w_cnt_run;
  logic               w_ovf_run;
  logic [GAP_W-1:0]   w_gap_run;
  logic               w_have_run;
  logic [GAP_W-1:0]   w_mgap_run;

  state_t             w_state_nxt;
  logic [WIN_W-1:0]   w_timer_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_have_nxt;
  logic [GAP_W-1:0]   w_mgap_nxt;
  logic               w_busy_nxt;
  logic               w_win_valid_nxt;
  logic [CNT_W-1:0]   w_win_count_nxt;
  logic               w_win_ovf_nxt;
  logic [GAP_W-1:0]   w_min_gap_nxt;

  assign w_rise = det_in & ~r_det_d;

  // Per-cycle window statistics update while a window is running.
  always_comb begin
    w_gap_inc  = (r_gap == GAP_MAX) ? GAP_MAX : r_gap + GAP_W'(1);
    w_cnt_run  = r_cnt;
    w_ovf_run  = r_ovf;
    w_gap_run  = r_gap;
    w_have_run = r_have_prev;
    w_mgap_run = r_mgap;
    if (w_rise) begin
      if (r_cnt == CNT_MAX) begin
        w_ovf_run = 1'b1;
      end else begin
        w_cnt_run = r_cnt + CNT_W'(1);
      end
      // gap counts cycles since the previous event, so spacing is gap+1
      if (r_have_prev && (w_gap_inc < r_mgap)) begin
        w_mgap_run = w_gap_inc;
      end
      w_gap_run  = '0;
      w_have_run = 1'b1;
    end else if (r_have_prev) begin
      w_gap_run = w_gap_inc;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_gap_nxt       = r_gap;
    w_have_nxt      = r_have_prev;
    w_mgap_nxt      = r_mgap;
    w_win_valid_nxt = 1'b0;
    w_win_count_nxt = r_win_count;
    w_win_ovf_nxt   = r_win_ovf;
    w_min_gap_nxt   = r_min_gap;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_gap_nxt   = '0;
        w_have_nxt  = 1'b0;
        w_mgap_nxt  = GAP_MAX;
        if (enable) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + WIN_W'(1);
          w_cnt_nxt   = w_cnt_run;
          w_ovf_nxt   = w_ovf_run;
          w_gap_nxt   = w_gap_run;
          w_have_nxt  = w_have_run;
          w_mgap_nxt  = w_mgap_run;
          // Last RUN cycle: publish stats including this cycle's event
          if (r_timer == TIMER_LAST) begin
            w_state_nxt     = S_REPORT;
            w_win_valid_nxt = 1'b1;
            w_win_count_nxt = w_cnt_run;
            w_win_ovf_nxt   = w_ovf_run;
            w_min_gap_nxt   = w_mgap_run;
          end
        end
      end
      S_REPORT: begin
        // Fresh window starts here; an event now is its first event
        w_timer_nxt = '0;
        w_cnt_nxt   = CNT_W'(w_rise);
        w_ovf_nxt   = 1'b0;
        w_gap_nxt   = '0;
        w_have_nxt  = w_rise;
        w_mgap_nxt  = GAP_MAX;
        w_state_nxt = enable ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (clear) begin
      w_state_nxt     = S_IDLE;
      w_timer_nxt     = '0;
      w_cnt_nxt       = '0;
      w_ovf_nxt       = 1'b0;
      w_gap_nxt       = '0;
      w_have_nxt      = 1'b0;
      w_mgap_nxt      = GAP_MAX;
      w_win_valid_nxt = 1'b0;
      w_win_count_nxt = '0;
      w_win_ovf_nxt   = 1'b0;
      w_min_gap_nxt   = GAP_MAX;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_det_d     <= 1'b0;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_gap       <= '0;
      r_have_prev <= 1'b0;
      r_mgap      <= GAP_MAX;
      r_busy      <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_count <= '0;
      r_win_ovf   <= 1'b0;
      r_min_gap   <= GAP_MAX;
    end else begin
      r_state     <= w_state_nxt;
      r_det_d     <= det_in;
      r_timer     <= w_timer_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_gap       <= w_gap_nxt;
      r_have_prev <= w_have_nxt;
      r_mgap      <= w_mgap_nxt;
      r_busy      <= w_busy_nxt;
      r_win_valid <= w_win_valid_nxt;
      r_win_count <= w_win_count_nxt;
      r_win_ovf   <= w_win_ovf_nxt;
      r_min_gap   <= w_min_gap_nxt;
    end
  end

  assign busy      = r_busy;
  assign win_valid = r_win_valid;
  assign win_count = r_win_count;
  assign win_ovf   = r_win_ovf;
  assign min_gap   = r_min_gap;

endmodule

// File: tb/tb_seq_det_event_window.sv
// Self-checking bench for seq_det_event_window.
// Two instances share stimulus: A (CNT_W=8, 20-cycle windows) and
// B (CNT_W=3, 40-cycle windows). A window-level model tracks event
// timestamps per instance and predicts every output after every edge.
module tb_seq_det_event_window;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       det_in;

  logic       a_busy, a_valid, a_ovf;
  logic [7:0] a_count, a_mgap;
  logic       b_busy, b_valid, b_ovf;
  logic [2:0] b_count;
  logic [7:0] b_mgap;

  int n_pass;
  int n_chk;

  seq_det_event_window #(.CNT_W(8), .GAP_W(8), .WIN_W(16), .WINDOW_CYCLES(20)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .det_in(det_in),
    .busy(a_busy), .win_valid(a_valid), .win_count(a_count), .win_ovf(a_ovf),
    .min_gap(a_mgap)
  );

  seq_det_event_window #(.CNT_W(3), .GAP_W(8), .WIN_W(16), .WINDOW_CYCLES(40)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .det_in(det_in),
    .busy(b_busy), .win_valid(b_valid), .win_count(b_count), .win_ovf(b_ovf),
    .min_gap(b_mgap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 counting a window, 2 report cycle
  int m_mode[2], m_t[2], m_n[2], m_last[2], m_mind[2];
  int e_valid[2], e_busy[2], e_count[2], e_ovf[2], e_mgap[2];
  int m_prev;
  int cyc_n;

  function automatic int win_len(input int k);
    return (k == 0) ? 20 : 40;
  endfunction

  function automatic int max_cnt(input int k);
    return (k == 0) ? 255 : 7;
  endfunction

  task automatic model_reset();
    m_prev = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_t[k] = 0; m_n[k] = 0; m_last[k] = -1; m_mind[k] = 255;
      e_valid[k] = 0; e_busy[k] = 0; e_count[k] = 0; e_ovf[k] = 0; e_mgap[k] = 255;
    end
  endtask

  task automatic model_event(input int k);
    if (m_last[k] >= 0) begin
      int d;
      d = cyc_n - m_last[k];
      if (d > 255) d = 255;
      if (d < m_mind[k]) m_mind[k] = d;
    end
    m_last[k] = cyc_n;
    m_n[k]++;
  endtask

  task automatic model_update(input logic en, input logic clr, input logic d);
    bit rise;
    rise = (d == 1'b1) && (m_prev == 0);
    m_prev = int'(d);
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 0;
      if (clr) begin
        m_mode[k] = 0;
        e_count[k] = 0; e_ovf[k] = 0; e_mgap[k] = 255;
      end else if (m_mode[k] == 0) begin
        if (en) begin
          m_mode[k] = 1; m_t[k] = 0; m_n[k] = 0; m_last[k] = -1; m_mind[k] = 255;
        end
      end else if (m_mode[k] == 1) begin
        if (!en) begin
          m_mode[k] = 0;
        end else begin
          if (rise) model_event(k);
          m_t[k]++;
          if (m_t[k] == win_len(k)) begin
            e_count[k] = (m_n[k] > max_cnt(k)) ? max_cnt(k) : m_n[k];
            e_ovf[k]   = (m_n[k] > max_cnt(k)) ? 1 : 0;
            e_mgap[k]  = m_mind[k];
            e_valid[k] = 1;
            m_mode[k]  = 2;
          end
        end
      end else begin
        m_t[k] = 0; m_n[k] = 0; m_last[k] = -1; m_mind[k] = 255;
        if (rise) model_event(k);
        m_mode[k] = en ? 1 : 0;
      end
      e_busy[k] = (m_mode[k] != 0) ? 1 : 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_all();
    chk("a_busy",  int'(a_busy),  e_busy[0]);
    chk("a_valid", int'(a_valid), e_valid[0]);
    chk("a_count", int'(a_count), e_count[0]);
    chk("a_ovf",   int'(a_ovf),   e_ovf[0]);
    chk("a_mgap",  int'(a_mgap),  e_mgap[0]);
    chk("b_busy",  int'(b_busy),  e_busy[1]);
    chk("b_valid", int'(b_valid), e_valid[1]);
    chk("b_count", int'(b_count), e_count[1]);
    chk("b_ovf",   int'(b_ovf),   e_ovf[1]);
    chk("b_mgap",  int'(b_mgap),  e_mgap[1]);
  endtask

  // Drive inputs for one cycle, take the edge, then compare.
  task automatic step(input logic en, input logic clr, input logic d);
    enable = en; clear = clr; det_in = d;
    @(posedge clk);
    model_update(en, clr, d);
    cyc_n++;
    #1;
    check_all();
  endtask

  // ---------------- directed window table (instance A) ----------------
  typedef struct {
    int p0;    // first pulse start (-1 none)
    int hold;  // cycles the first pulse stays high
    int p1;    // extra single-cycle pulses (-1 none)
    int p2;
    int e_cnt;
    int e_mg;
  } win_vec_t;

  win_vec_t tbl[6];

  function automatic logic pat(input win_vec_t v, input int t);
    return ((v.p0 >= 0) && (t >= v.p0) && (t < v.p0 + v.hold)) ||
           (t == v.p1) || (t == v.p2);
  endfunction

  initial begin
    n_pass = 0; n_chk = 0; cyc_n = 0;
    tbl[0] = '{p0: 2,  hold: 1,  p1: 6,  p2: 9,  e_cnt: 3, e_mg: 3};
    tbl[1] = '{p0: 3,  hold: 10, p1: -1, p2: -1, e_cnt: 1, e_mg: 255};
    tbl[2] = '{p0: 0,  hold: 1,  p1: 19, p2: -1, e_cnt: 2, e_mg: 19};
    tbl[3] = '{p0: -1, hold: 1,  p1: -1, p2: -1, e_cnt: 0, e_mg: 255};
    tbl[4] = '{p0: 4,  hold: 1,  p1: 6,  p2: -1, e_cnt: 2, e_mg: 2};
    tbl[5] = '{p0: 5,  hold: 1,  p1: 10, p2: 15, e_cnt: 3, e_mg: 5};

    reset = 1'b1; enable = 1'b0; clear = 1'b0; det_in = 1'b0;
    model_reset();
    #2;
    check_all();
    #10 reset = 1'b0;

    // Back-to-back windows on A; the report step of the last entry carries a pulse
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 20; t++) step(1'b1, 1'b0, pat(tbl[i], t));
      chk($sformatf("tbl%0d_valid", i), int'(a_valid), 1);
      chk($sformatf("tbl%0d_count", i), int'(a_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_mgap", i),  int'(a_mgap),  tbl[i].e_mg);
      chk($sformatf("tbl%0d_ovf", i),   int'(a_ovf),   0);
      step(1'b1, 1'b0, (i == 5) ? 1'b1 : 1'b0);
    end

    // Pulse in the REPORT cycle belongs to the following window
    for (int t = 0; t < 20; t++) step(1'b1, 1'b0, 1'b0);
    chk("report_pulse_valid", int'(a_valid), 1);
    chk("report_pulse_count", int'(a_count), 1);
    chk("report_pulse_mgap",  int'(a_mgap),  255);
    step(1'b1, 1'b0, 1'b0);

    // Abort by dropping enable at RUN cycle 10
    for (int t = 0; t < 10; t++) step(1'b1, 1'b0, (t == 3) ? 1'b1 : 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("abort_busy",  int'(a_busy),  0);
    chk("abort_valid", int'(a_valid), 0);
    chk("abort_count", int'(a_count), 1);
    step(1'b0, 1'b0, 1'b0);

    // Clear mid-RUN
    step(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) step(1'b1, 1'b0, (t == 2) ? 1'b1 : 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clear_busy",  int'(a_busy),  0);
    chk("clear_count", int'(a_count), 0);
    chk("clear_mgap",  int'(a_mgap),  255);

    // Saturation on B: 10 pulses spaced 3 apart
    step(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 40; t++)
      step(1'b1, 1'b0, (t >= 1 && t <= 28 && ((t - 1) % 3) == 0) ? 1'b1 : 1'b0);
    chk("sat_valid", int'(b_valid), 1);
    chk("sat_count", int'(b_count), 7);
    chk("sat_ovf",   int'(b_ovf),   1);
    chk("sat_mgap",  int'(b_mgap),  3);
    step(1'b0, 1'b0, 1'b0);

    // Async reset mid-window after 5 events
    step(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) step(1'b1, 1'b0, (t < 10 && (t % 2) == 1) ? 1'b1 : 1'b0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_busy",  int'(a_busy),  0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_count", int'(a_count), 0);
    chk("rst_mgap",  int'(a_mgap),  255);
    check_all();
    #1 reset = 1'b0;

    // Restart: a fresh window sees only the new events
    step(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) step(1'b1, 1'b0, (t == 2 || t == 12) ? 1'b1 : 1'b0);
    chk("restart_valid", int'(a_valid), 1);
    chk("restart_count", int'(a_count), 2);
    chk("restart_mgap",  int'(a_mgap),  10);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_det_event_window.md
Name: seq_det_event_window

Overview:
- Downstream consumer of the serial sequence-detector output (the Moore-type, non-overlapping "101" detector pulse).
- Counts detection events over fixed windows of clock cycles.
- At each window end, reports the event count, an overflow flag and the minimum spacing between consecutive events.
- Feeds status registers and rate monitoring logic.

Parameters:
- CNT_W, 8: width of per-window event count.
- GAP_W, 8: width of gap/minimum-gap counters.
- WIN_W, 16: width of window timer.
- WINDOW_CYCLES, 100: window length in clock cycles. Legal range is 2 to 2^WIN_W-1.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; high = run windows back-to-back.
- clear  input  1  synchronous abort/clear pulse.
- det_in  input  1  detector output (q_out of upstream detector).
- busy  output  1  high while in RUN or REPORT.
- win_valid  output  1  one-cycle pulse; the report outputs below are valid.
- win_count  output  CNT_W  events in the completed window, saturating.
- win_ovf  output  1  count saturated during the window.
- min_gap  output  GAP_W  minimum cycles between consecutive events; all-ones if fewer than 2 events.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All counters 0; det_d=0.
  - win_valid=0, win_count=0, win_ovf=0, min_gap=all-ones, busy=0.
- Event definition:
  - rise = det_in & ~det_d. det_d is registered every cycle in every state.
  - A level held high counts once.
  - det_in already high at IDLE->RUN counts if det_d=0.
- States:
  - IDLE: enable=1 -> RUN on the next edge; timer=0, cnt=0, gap=0, have_prev=0, mgap=all-ones.
  - RUN: timer increments every cycle. When timer==WINDOW_CYCLES-1, next state is REPORT. A rise in that last cycle is still counted.
  - REPORT (exactly one cycle):
    - win_valid=1.
    - win_count/win_ovf/min_gap load the final window values; they hold until the next REPORT, clear or reset.
    - Internal counters restart in the same cycle.
    - A rise during REPORT belongs to the new window: cnt=1, have_prev=1, gap=0.
    - Next state is RUN if enable=1, else IDLE.
- Count rules:
  - cnt+1 on rise. At 2^CNT_W-1 it holds, and ovf sets sticky for the window.
- Gap rules:
  - gap increments each RUN cycle after the first event, saturating at all-ones.
  - On a rise with have_prev=1: mgap=min(mgap, gap+1) (saturating), then gap=0.
  - On the first rise: have_prev=1, gap=0.
  - Consecutive-cycle events cannot occur (rise needs a low in between), so the minimum reportable gap is 2.
- enable deassert in RUN: window aborted; next state IDLE; no win_valid; report outputs unchanged.
- clear=1:
  - Priority over all except reset.
  - Next edge: IDLE, internal counters cleared, report outputs to reset values, win_valid=0.
- busy = (state != IDLE), registered with the state.
- Window length: exactly WINDOW_CYCLES RUN cycles, then one REPORT cycle. Back-to-back period = WINDOW_CYCLES+1 cycles.

Test Plan:
- Reset (WINDOW_CYCLES=20): assert reset mid-clock -> outputs go to reset values immediately, without a clock edge; busy=0, min_gap=8'hFF.
- Basic window (WINDOW_CYCLES=20, enable=1 held):
  - Stimulus: single-cycle det_in pulses in RUN cycles 2, 6 and 9.
  - Response: win_valid exactly one cycle on the 21st cycle after RUN entry; win_count=3, min_gap=3, win_ovf=0.
- Held level and edge cases:
  - det_in high for 10 cycles -> win_count=1, min_gap=8'hFF.
  - Pulse in the last RUN cycle is counted in the current window.
  - Pulse in the REPORT cycle gives the next window win_count>=1.
- Saturation (CNT_W=3, WINDOW_CYCLES=40): 10 pulses spaced 3 cycles apart -> win_count=7, win_ovf=1, min_gap=3.
- Abort:
  - enable dropped at RUN cycle 10 -> no win_valid, busy=0 next cycle, prior report outputs unchanged.
  - clear pulse mid-RUN -> IDLE and outputs at reset values.
- Reset mid-window after 5 events -> all outputs reset asynchronously.
- Restart with enable=1 after reset -> a fresh window reports only the new events.
